// File: rtl/rename_pkg.sv
// rename_pkg: shared defaults and width helpers for the register rename slice.
//   DEF_NUM_ARCH_REGS / DEF_NUM_PHYS_REGS : default register file sizes
//   aw_of / pw_of                         : index widths for arch / phys regs
package rename_pkg;

   localparam int DEF_NUM_ARCH_REGS = 32;
   localparam int DEF_NUM_PHYS_REGS = 64;

   function automatic int aw_of(input int num_arch_regs);
      return $clog2(num_arch_regs);
   endfunction

   function automatic int pw_of(input int num_phys_regs);
      return $clog2(num_phys_regs);
   endfunction

endpackage

// File: rtl/rename_if.sv
// rename_if: issue, retire, flush and status signals of the rename unit.
//   master : the pipeline side (issues renames, retires, flushes)
//   slave  : the rename unit
interface rename_if
   import rename_pkg::*;
#(
   parameter int NUM_ARCH_REGS = DEF_NUM_ARCH_REGS,
   parameter int NUM_PHYS_REGS = DEF_NUM_PHYS_REGS
);
   localparam int AW = aw_of(NUM_ARCH_REGS);
   localparam int PW = pw_of(NUM_PHYS_REGS);

   // issue side
   logic          issue_valid;
   logic          issue_ready;
   logic [AW-1:0] rs1;
   logic [AW-1:0] rs2;
   logic [AW-1:0] rd;
   logic          rd_write;
   logic [PW-1:0] phys_rs1;
   logic [PW-1:0] phys_rs2;
   logic [PW-1:0] phys_rd;
   logic [PW-1:0] old_phys_rd;

   // retire / recovery side
   logic          retire_valid;
   logic          retire_rd_write;
   logic [AW-1:0] retire_rd;
   logic [PW-1:0] retire_phys_rd;
   logic [PW-1:0] retire_old_phys_rd;
   logic          flush;

   logic [PW:0]   free_count;

   modport master (
      output issue_valid, rs1, rs2, rd, rd_write,
      output retire_valid, retire_rd_write, retire_rd, retire_phys_rd, retire_old_phys_rd, flush,
      input  issue_ready, phys_rs1, phys_rs2, phys_rd, old_phys_rd, free_count
   );

   modport slave (
      input  issue_valid, rs1, rs2, rd, rd_write,
      input  retire_valid, retire_rd_write, retire_rd, retire_phys_rd, retire_old_phys_rd, flush,
      output issue_ready, phys_rs1, phys_rs2, phys_rd, old_phys_rd, free_count
   );

endinterface

// File: rtl/rename_free_list.sv
// rename_free_list: circular FIFO of free physical registers.
//   clk, reset_n : clock, async active-low reset
//   pop          : allocation consumes head entry
//   push         : retirement appends push_data at tail (also advances rhead)
//   restore      : flush recovery, head <= rhead (including this cycle's push)
//   head_data    : entry at head (next register to allocate)
//   count        : number of free entries (tail - head)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rename_free_list
   import rename_pkg::*;
#(
   parameter int NUM_ARCH_REGS = DEF_NUM_ARCH_REGS,
   parameter int NUM_PHYS_REGS = DEF_NUM_PHYS_REGS,
   localparam int PW = pw_of(NUM_PHYS_REGS)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          pop,
   input  logic          push,
   input  logic [PW-1:0] push_data,
   input  logic          restore,
   output logic [PW-1:0] head_data,
   output logic [PW:0]   count
);
   localparam int FL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
   localparam int IW       = $clog2(FL_DEPTH);

   logic [FL_DEPTH-1:0][PW-1:0] fl;
   logic [IW:0]                 head, tail, rhead, rhead_nxt;

   // rhead tracks the retired allocation point; every retire push moves it
   assign rhead_nxt = rhead + (IW+1)'(push);
   assign head_data = fl[head[IW-1:0]];
   assign count     = (PW+1)'(tail - head);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j < FL_DEPTH; j++)
            fl[j] <= PW'(NUM_ARCH_REGS + j);
         head  <= '0;
         rhead <= '0;
         tail  <= {1'b1, {IW{1'b0}}};    // full: every non-arch reg is free
      end else begin
         if (push) begin
            fl[tail[IW-1:0]] <= push_data;
            tail             <= tail + 1'b1;
         end
         rhead <= rhead_nxt;
         // restore discards every speculative pop, so it overrides pop
         if (restore)
            head <= rhead_nxt;
         else if (pop)
            head <= head + 1'b1;
      end
   end

endmodule

// File: rtl/rename_unit.sv
// rename_unit: maps architectural to physical registers for an OoO core.
//   clk, reset_n : clock, async active-low reset
//   rif (slave)  : issue request/response, in-order retire, flush, free_count
// SRAT holds speculative mappings read at issue; RRAT holds retired mappings
// and is copied into SRAT on flush. Register 0 always maps to phys 0.
module rename_unit
   import rename_pkg::*;
#(
   parameter int NUM_ARCH_REGS = DEF_NUM_ARCH_REGS,
   parameter int NUM_PHYS_REGS = DEF_NUM_PHYS_REGS
) (
   input  logic clk,
   input  logic reset_n,
   rename_if.slave rif
);
   localparam int AW = aw_of(NUM_ARCH_REGS);
   localparam int PW = pw_of(NUM_PHYS_REGS);

   logic [NUM_ARCH_REGS-1:0][PW-1:0] srat, rrat, rrat_nxt;
   logic [PW-1:0]                    fl_head;
   logic [PW:0]                      fl_count;
   logic                             wants_alloc, accept, alloc, ret_wr;

   assign wants_alloc = rif.rd_write && (rif.rd != '0);
   assign accept      = rif.issue_valid && rif.issue_ready;
   assign alloc       = accept && wants_alloc;
   assign ret_wr      = rif.retire_valid && rif.retire_rd_write && (rif.retire_rd != '0);

   // an empty free list only blocks instructions that need a new register
   assign rif.issue_ready = !rif.flush && (fl_count != '0 || !wants_alloc);
   assign rif.free_count  = fl_count;

   // all reads use pre-cycle SRAT, so rs == rd sees the old mapping
   assign rif.phys_rs1    = srat[rif.rs1];
   assign rif.phys_rs2    = srat[rif.rs2];
   assign rif.old_phys_rd = srat[rif.rd];
   assign rif.phys_rd     = wants_alloc ? fl_head : srat[rif.rd];

   // retire-updated RRAT, shared by the RRAT flops and flush recovery
   always_comb begin
      rrat_nxt = rrat;
      if (ret_wr)
         rrat_nxt[rif.retire_rd] = rif.retire_phys_rd;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            srat[i] <= PW'(i);
            rrat[i] <= PW'(i);
         end
      end else begin
         rrat <= rrat_nxt;
         if (rif.flush)
            srat <= rrat_nxt;
         else if (alloc)
            srat[rif.rd] <= fl_head;
      end
   end

   rename_free_list #(
      .NUM_ARCH_REGS (NUM_ARCH_REGS),
      .NUM_PHYS_REGS (NUM_PHYS_REGS)
   ) u_free_list (
      .clk       (clk),
      .reset_n   (reset_n),
      .pop       (alloc),
      .push      (ret_wr),
      .push_data (rif.retire_old_phys_rd),
      .restore   (rif.flush),
      .head_data (fl_head),
      .count     (fl_count)
   );

endmodule
